// File: rtl/pm_field_pkg.sv
// Shared constants for the pseudo-Mersenne field multiplier (P = 2^W - C).
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package pm_field_pkg;

  localparam int W_DEF     = 255;
  localparam int C_DEF     = 19;
  localparam int TAG_W_DEF = 4;

  // Karatsuba split point: the low half gets the extra bit when W is odd.
  function automatic int half_w(input int w);
    return (w + 1) / 2;
  endfunction

  // Bits needed to hold the pseudo-Mersenne constant C.
  function automatic int c_bits(input int c);
    return $clog2(c + 1);
  endfunction

  // Derived constants for the default field.
  localparam int               H = half_w(W_DEF);
  localparam logic [W_DEF-1:0] P = {W_DEF{1'b1}} - W_DEF'(C_DEF - 1);

  // Intermediate widths for the default field.
  localparam int OP_W   = 2 * H;                // zero-extended operand
  localparam int MID_W  = 2 * H + 2;            // (a_hi+a_lo)*(b_hi+b_lo)
  localparam int PROD_W = 2 * W_DEF;            // full product a*b
  localparam int FOLD1_W = W_DEF + c_bits(C_DEF); // hi*C + lo
  localparam int FOLD2_W = W_DEF + 1;           // second fold, < 2P

endpackage

// File: rtl/pm_karatsuba_mul.sv
// Two-stage Karatsuba multiplier core: S0 splits and forms half-sums, S1 forms three partial products.
// Latency: 2 cycles from operands to partial products when en is held high.
// Backpressure: en low freezes both stages; the caller derives en from its own handshake.
module pm_karatsuba_mul #(
  parameter int H = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*H-1:0] a,
  input  logic [2*H-1:0] b,
  output logic [2*H-1:0] p_lo,
  output logic [2*H-1:0] p_hi,
  output logic [2*H+1:0] p_mid
);

  localparam int DW = 2 * H;
  localparam int MW = 2 * H + 2;

  logic [H-1:0]  a_lo_d, a_lo_q, a_hi_d, a_hi_q;
  logic [H-1:0]  b_lo_d, b_lo_q, b_hi_d, b_hi_q;
  logic [H:0]    sa_d, sa_q, sb_d, sb_q;
  logic [DW-1:0] p_lo_d, p_lo_q, p_hi_d, p_hi_q;
  logic [MW-1:0] p_mid_d, p_mid_q;

  // S0: split both operands into halves and form the half-sums, hold on stall
  always_comb begin
    a_lo_d = a_lo_q;
    a_hi_d = a_hi_q;
    b_lo_d = b_lo_q;
    b_hi_d = b_hi_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    if (en) begin
      a_lo_d = a[H-1:0];
      a_hi_d = a[DW-1:H];
      b_lo_d = b[H-1:0];
      b_hi_d = b[DW-1:H];
      sa_d   = {1'b0, a[DW-1:H]} + {1'b0, a[H-1:0]};
      sb_d   = {1'b0, b[DW-1:H]} + {1'b0, b[H-1:0]};
    end
  end

  // S1: three half-width products; the cross term is recovered later by subtraction
  always_comb begin
    p_lo_d  = p_lo_q;
    p_hi_d  = p_hi_q;
    p_mid_d = p_mid_q;
    if (en) begin
      p_lo_d  = DW'(a_lo_q) * DW'(b_lo_q);
      p_hi_d  = DW'(a_hi_q) * DW'(b_hi_q);
      p_mid_d = MW'(sa_q) * MW'(sb_q);
    end
  end

  // Stage registers for S0 and S1
  always_ff @(posedge clk) begin
    if (rst) begin
      a_lo_q  <= '0;
      a_hi_q  <= '0;
      b_lo_q  <= '0;
      b_hi_q  <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      p_lo_q  <= '0;
      p_hi_q  <= '0;
      p_mid_q <= '0;
    end else begin
      a_lo_q  <= a_lo_d;
      a_hi_q  <= a_hi_d;
      b_lo_q  <= b_lo_d;
      b_hi_q  <= b_hi_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      p_lo_q  <= p_lo_d;
      p_hi_q  <= p_hi_d;
      p_mid_q <= p_mid_d;
    end
  end

  assign p_lo  = p_lo_q;
  assign p_hi  = p_hi_q;
  assign p_mid = p_mid_q;

endmodule

// File: rtl/pm_field_mult.sv
// Pipelined (a*b) mod (2^W - C) with optional squaring and an opaque tag, fully reduced output.
// Latency: 4 cycles from acceptance to out_valid, one operation per cycle.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready = !out_valid || out_ready.
module pm_field_mult
  import pm_field_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int C     = C_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sqr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam int HW  = half_w(W);
  localparam int OPW = 2 * HW;
  localparam int MDW = 2 * HW + 2;
  localparam int PDW = 2 * W;
  localparam int FW1 = W + c_bits(C);
  localparam int FW2 = W + 1;
  localparam logic [W-1:0] P_MOD = {W{1'b1}} - W'(C - 1);

  logic             adv;
  logic [W-1:0]     b_sel;
  logic [OPW-1:0]   k_lo, k_hi;
  logic [MDW-1:0]   k_mid;
  logic [MDW-1:0]   mid;
  logic [PDW-1:0]   prod;
  logic [FW1-1:0]   f1_new, f1_d, f1_q;
  logic [FW2-1:0]   f2;
  logic [W-1:0]     res_new, res_d, res_q;
  logic [3:0]       vld_d, vld_q;
  logic [TAG_W-1:0] tag_d [4];
  logic [TAG_W-1:0] tag_q [4];

  // Output valid is forced low during reset so nothing leaks out while clearing.
  assign out_valid = vld_q[3] & ~rst;
  assign in_ready  = ~out_valid | out_ready;
  assign adv       = in_ready;
  assign out_res   = out_valid ? res_q : '0;
  assign out_tag   = out_valid ? tag_q[3] : '0;

  // Squaring reuses the general multiplier with b tied to a.
  assign b_sel = in_sqr ? in_a : in_b;

  pm_karatsuba_mul #(
    .H (HW)
  ) u_kmul (
    .clk   (clk),
    .rst   (rst),
    .en    (adv),
    .a     (OPW'(in_a)),
    .b     (OPW'(b_sel)),
    .p_lo  (k_lo),
    .p_hi  (k_hi),
    .p_mid (k_mid)
  );

  // S2/S3 arithmetic: recombine, fold twice using 2^W == C, then one subtraction of P.
  // After the second fold the value is below 2^W + C^2 < 2P, so one compare against P
  // (full-width, not a sign test on a truncated value) always lands in 0..P-1.
  always_comb begin
    mid     = k_mid - MDW'(k_hi) - MDW'(k_lo);
    prod    = (PDW'(k_hi) << (2 * HW)) + (PDW'(mid) << HW) + PDW'(k_lo);
    f1_new  = FW1'(prod[PDW-1:W]) * FW1'(C) + FW1'(prod[W-1:0]);
    f2      = FW2'(f1_q[FW1-1:W]) * FW2'(C) + FW2'(f1_q[W-1:0]);
    res_new = (f2 >= FW2'(P_MOD)) ? W'(f2 - FW2'(P_MOD)) : W'(f2);
  end

  // Stage advance: all stages shift together when the output slot can move, else hold
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < 4; i++) begin
      tag_d[i] = tag_q[i];
    end
    f1_d  = f1_q;
    res_d = res_q;
    if (adv) begin
      vld_d    = {vld_q[2:0], in_valid};
      tag_d[0] = in_tag;
      tag_d[1] = tag_q[0];
      tag_d[2] = tag_q[1];
      tag_d[3] = tag_q[2];
      f1_d     = f1_new;
      res_d    = res_new;
    end
  end

  // Valid bits, tags and the S2/S3 data registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= '0;
      end
      f1_q  <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= tag_d[i];
      end
      f1_q  <= f1_d;
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_pm_field_mult.sv
// Directed bench for pm_field_mult: vector table plus stall and reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// All expected values are hand-derived constants mod P = 2^255 - 19.
module tb_pm_field_mult;

  localparam logic [254:0] ONES = {255{1'b1}};
  localparam logic [254:0] TP   = ONES - 255'd18;   // 2^255 - 19

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [254:0] in_a;
  logic [254:0] in_b;
  logic         in_sqr;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] out_res;
  logic [3:0]   out_tag;

  int n_assert;
  int n_fail;

  typedef struct {
    logic [254:0] a;
    logic [254:0] b;
    logic         sqr;
    logic [3:0]   tag;
    logic [254:0] exp;
  } vec_t;

  vec_t vecs [15];

  pm_field_mult #(
    .W     (255),
    .C     (19),
    .TAG_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sqr    (in_sqr),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_sqr    = v.sqr;
    in_tag    = v.tag;
    out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sqr   = 1'b0;
    in_tag   = '0;
    #1;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("vec%0d_latency", idx), cyc, 4);
    chk($sformatf("vec%0d_res", idx), out_res, v.exp);
    chk($sformatf("vec%0d_tag", idx), out_tag, v.tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           cyc;
    int           sent;
    int           got;
    int           nval;
    int           first;
    logic         prev_stall;
    logic [254:0] prev_res;
    logic [3:0]   prev_tag;

    n_assert = 0;
    n_fail   = 0;

    vecs[0]  = '{TP - 255'd1, TP - 255'd1, 1'b0, 4'd5, 255'd1};
    vecs[1]  = '{ONES, 255'd1, 1'b0, 4'd1, 255'd18};
    vecs[2]  = '{ONES, ONES, 1'b0, 4'd2, 255'd324};
    vecs[3]  = '{255'd2, ONES, 1'b1, 4'd3, 255'd4};
    vecs[4]  = '{255'd2, 255'd3, 1'b0, 4'd4, 255'd6};
    vecs[5]  = '{255'd1 << 254, 255'd2, 1'b0, 4'd6, 255'd19};
    vecs[6]  = '{255'd1 << 128, 255'd1 << 128, 1'b0, 4'd7, 255'd38};
    vecs[7]  = '{255'd0, ONES, 1'b0, 4'd8, 255'd0};
    vecs[8]  = '{TP, 255'd5, 1'b0, 4'd9, 255'd0};
    vecs[9]  = '{TP + 255'd1, 255'd7, 1'b0, 4'd10, 255'd7};
    vecs[10] = '{255'd1 << 200, 255'd1 << 100, 1'b0, 4'd11, 255'd19 << 45};
    vecs[11] = '{TP - 255'd1, 255'd2, 1'b0, 4'd12, TP - 255'd2};
    vecs[12] = '{ONES, 255'd0, 1'b1, 4'd13, 255'd324};
    vecs[13] = '{TP, 255'd1, 1'b0, 4'd14, 255'd0};
    vecs[14] = '{255'd3, 255'd5, 1'b0, 4'd15, 255'd15};

    // Reset held for 3 cycles while in_valid is asserted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = ONES;
    in_b      = ONES;
    in_sqr    = 1'b0;
    in_tag    = 4'hf;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst%0d_out_valid", i), out_valid, 0);
      chk($sformatf("rst%0d_out_res", i), out_res, 0);
      chk($sformatf("rst%0d_out_tag", i), out_tag, 0);
      chk($sformatf("rst%0d_in_ready", i), in_ready, 1);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    nval     = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) nval++;
      @(negedge clk);
    end
    chk("post_rst_quiet", nval, 0);

    // Single-operation vectors.
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back stream with a 4-cycle stall in the middle.
    sent       = 0;
    got        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_tag   = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 10);
      in_valid  = (sent < 8);
      in_a      = TP + 255'(sent + 1);
      in_b      = 255'(sent + 3);
      in_sqr    = 1'b0;
      in_tag    = 4'(sent);
      #1;
      if (prev_stall) begin
        chk($sformatf("bp_c%0d_hold_valid", cyc), out_valid, 1);
        chk($sformatf("bp_c%0d_hold_res", cyc), out_res, prev_res);
        chk($sformatf("bp_c%0d_hold_tag", cyc), out_tag, prev_tag);
      end
      if (out_valid && !out_ready) begin
        chk($sformatf("bp_c%0d_in_ready_low", cyc), in_ready, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_tag   = out_tag;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d_tag", got), out_tag, 4'(got));
        chk($sformatf("bp_out%0d_res", got), out_res, 255'((got + 1) * (got + 3)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("bp_all_delivered", got, 8);
    chk("bp_all_sent", sent, 8);

    // Reset pulse with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_a      = 255'(i + 10);
      in_b      = 255'd2;
      in_sqr    = 1'b0;
      in_tag    = 4'(i + 1);
      out_ready = 1'b1;
      #1;
      chk($sformatf("mid_op%0d_in_ready", i), in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_out_valid", out_valid, 0);
    in_valid = 1'b1;
    in_a     = 255'd7;
    in_b     = 255'd9;
    in_tag   = 4'd9;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    nval  = 0;
    first = -1;
    cyc   = 1;
    while (cyc <= 12) begin
      if (out_valid) begin
        nval++;
        if (first < 0) first = cyc;
        chk($sformatf("after_rst_c%0d_res", cyc), out_res, 255'd63);
        chk($sformatf("after_rst_c%0d_tag", cyc), out_tag, 4'd9);
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("after_rst_result_count", nval, 1);
    chk("after_rst_latency", 255'(first), 255'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
